// File: rtl/key_debounce_array_if.sv
// Key array bundle: raw switch pins and repeat enables in, debounced level
// and one-cycle event pulses out.
//   PSW       raw asynchronous switch pins (master -> slave)
//   RPT_EN    per-channel auto-repeat enable (master -> slave)
//   KEY_LVL   debounced pressed level (slave -> master)
//   KEY_PRESS / KEY_REL / KEY_LONG / KEY_RPT  event pulses (slave -> master)
// master = the side driving the pins, slave = the debouncer.
interface key_debounce_array_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] PSW;
    logic [N_KEYS-1:0] RPT_EN;
    logic [N_KEYS-1:0] KEY_LVL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_REL;
    logic [N_KEYS-1:0] KEY_LONG;
    logic [N_KEYS-1:0] KEY_RPT;

    modport master (
        output PSW,
        output RPT_EN,
        input  KEY_LVL,
        input  KEY_PRESS,
        input  KEY_REL,
        input  KEY_LONG,
        input  KEY_RPT
    );

    modport slave (
        input  PSW,
        input  RPT_EN,
        output KEY_LVL,
        output KEY_PRESS,
        output KEY_REL,
        output KEY_LONG,
        output KEY_RPT
    );
endinterface

// File: rtl/key_debounce_array.sv
// Independent push-switch debouncers with press/release/long-press and
// auto-repeat event generation, one channel per key.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  key_debounce_array_if.slave (pins and enables in, level and pulses out)
module key_debounce_array #(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 25000000,
    parameter int RPT_CYCLES  = 5000000,
    parameter int ACTIVE_LOW  = 1
) (
    input logic                 CLK,
    input logic                 RST,
    key_debounce_array_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(RPT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_CYCLES - 1);

    // Pin level of a released key; also the synchroniser reset value.
    localparam logic [N_KEYS-1:0] IDLE_PINS = {N_KEYS{(ACTIVE_LOW != 0)}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] lvl_q, lvl_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] rel_q, rel_d;
    logic [N_KEYS-1:0] long_q, long_d;
    logic [N_KEYS-1:0] rpt_q, rpt_d;
    logic [N_KEYS-1:0] s_pressed;
    logic [N_KEYS-1:0] flip;

    logic [DW-1:0] deb_q  [N_KEYS];
    logic [DW-1:0] deb_d  [N_KEYS];
    logic [HW-1:0] hold_q [N_KEYS];
    logic [HW-1:0] hold_d [N_KEYS];
    logic [RW-1:0] rcnt_q [N_KEYS];
    logic [RW-1:0] rcnt_d [N_KEYS];
    state_e        state_q [N_KEYS];
    state_e        state_d [N_KEYS];

    // Synchroniser and polarity normalisation (s_pressed: 1 = pressed).
    always_comb begin
        sync1_d   = bus.PSW;
        sync2_d   = sync1_q;
        s_pressed = sync2_q ^ IDLE_PINS;
    end

    // Debounce: accept a new level after DEB_CYCLES differing cycles.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            deb_d[i] = '0;
            if (s_pressed[i] != lvl_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    flip[i] = 1'b1;
                end else begin
                    deb_d[i] = deb_q[i] + DW'(1);
                end
            end
        end
        lvl_d   = lvl_q ^ flip;
        press_d = flip & ~lvl_q;
        rel_d   = flip & lvl_q;
    end

    // Hold / repeat FSM; an accepted release overrides any pending pulse.
    always_comb begin
        long_d = '0;
        rpt_d  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            rcnt_d[i]  = rcnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (press_d[i]) begin
                        state_d[i] = PRESSED;
                        hold_d[i]  = '0;
                        rcnt_d[i]  = '0;
                        rpt_d[i]   = bus.RPT_EN[i];
                    end
                end
                PRESSED: begin
                    if (rel_d[i]) begin
                        state_d[i] = IDLE;
                        hold_d[i]  = '0;
                        rcnt_d[i]  = '0;
                    end else if (hold_q[i] == HOLD_LAST) begin
                        state_d[i] = HELD;
                        long_d[i]  = 1'b1;
                        hold_d[i]  = '0;
                        rcnt_d[i]  = '0;
                    end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                    end
                end
                HELD: begin
                    if (rel_d[i]) begin
                        state_d[i] = IDLE;
                        hold_d[i]  = '0;
                        rcnt_d[i]  = '0;
                    end else if (!bus.RPT_EN[i]) begin
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == RPT_LAST) begin
                        rcnt_d[i] = '0;
                        rpt_d[i]  = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    hold_d[i]  = '0;
                    rcnt_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= IDLE_PINS;
            sync2_q <= IDLE_PINS;
            lvl_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            rpt_q   <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_q[i]   <= deb_d[i];
                hold_q[i]  <= hold_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign bus.KEY_LVL   = lvl_q;
    assign bus.KEY_PRESS = press_q;
    assign bus.KEY_REL   = rel_q;
    assign bus.KEY_LONG  = long_q;
    assign bus.KEY_RPT   = rpt_q;
endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array: directed scenarios followed by
// random pin activity, checked against a window-based reference model.
module tb_key_debounce_array;
    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int RPT  = 5;
    localparam int MAXC = 8192;

    logic CLK = 1'b0;
    logic RST;

    key_debounce_array_if #(.N_KEYS(N)) bus ();

    key_debounce_array #(
        .N_KEYS     (N),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .RPT_CYCLES (RPT),
        .ACTIVE_LOW (1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] rpt;
    } obs_t;

    obs_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;

    // Reference model: pressed-view history per cycle and event bookkeeping.
    int edge_n = 0;
    bit s_at       [N][MAXC];
    bit m_lvl      [N];
    int m_flip_at  [N];
    bit m_pin_prev [N];
    bit m_active   [N];
    bit m_held     [N];
    int m_press_at [N];
    int m_run      [N];

    logic [N-1:0] pin_v;
    logic [N-1:0] en_v;

    // A level is accepted when the synchronised view has disagreed with it
    // for the last DEB cycles, all of them after the previous acceptance.
    task automatic model_edge(input bit rst, input logic [N-1:0] pin,
                              input logic [N-1:0] en, output obs_t o);
        o = '0;
        for (int c = 0; c < N; c++) begin
            bit flip;
            flip = 1'b0;
            if (rst) begin
                m_lvl[c]      = 1'b0;
                m_flip_at[c]  = edge_n;
                m_active[c]   = 1'b0;
                m_held[c]     = 1'b0;
                m_run[c]      = 0;
                s_at[c][edge_n] = 1'b0;
                m_pin_prev[c] = 1'b1;
            end else begin
                if (edge_n - DEB >= m_flip_at[c]) begin
                    flip = 1'b1;
                    for (int k = 1; k <= DEB; k++)
                        if (s_at[c][edge_n-k] == m_lvl[c]) flip = 1'b0;
                end
                s_at[c][edge_n] = ~m_pin_prev[c];
                m_pin_prev[c]   = pin[c];
                if (flip) begin
                    m_flip_at[c] = edge_n;
                    if (!m_lvl[c]) begin
                        o.press[c]    = 1'b1;
                        o.rpt[c]      = en[c];
                        m_active[c]   = 1'b1;
                        m_held[c]     = 1'b0;
                        m_press_at[c] = edge_n;
                    end else begin
                        o.rel[c]    = 1'b1;
                        m_active[c] = 1'b0;
                        m_held[c]   = 1'b0;
                    end
                    m_lvl[c] = ~m_lvl[c];
                end else if (m_active[c] && !m_held[c]) begin
                    if (edge_n - m_press_at[c] == LONG) begin
                        o.lng[c]  = 1'b1;
                        m_held[c] = 1'b1;
                        m_run[c]  = 0;
                    end
                end else if (m_active[c]) begin
                    m_run[c] = en[c] ? m_run[c] + 1 : 0;
                    if (en[c] && (m_run[c] % RPT == 0)) o.rpt[c] = 1'b1;
                end
            end
            o.lvl[c] = m_lvl[c];
        end
        edge_n++;
    endtask

    task automatic cyc(input bit rst, input logic [N-1:0] pin,
                       input logic [N-1:0] en);
        obs_t o;
        @(negedge CLK);
        RST        = rst;
        bus.PSW    = pin;
        bus.RPT_EN = en;
        model_edge(rst, pin, en, o);
        exp_q.push_back(o);
        pushed++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, pin_v, en_v);
    endtask

    // Monitor: one expected record per clock edge driven by the stimulus.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                popped++;
                a = {bus.KEY_LVL, bus.KEY_PRESS, bus.KEY_REL,
                     bus.KEY_LONG, bus.KEY_RPT};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs edge %0d lvl/press/rel/long/rpt got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                             popped - 1, a.lvl, a.press, a.rel, a.lng, a.rpt,
                             e.lvl, e.press, e.rel, e.lng, e.rpt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout popped=%0d pushed=%0d", popped, pushed);
        $fatal(1, "timeout");
    end

    initial begin
        int rem [N];
        int j;
        RST        = 1'b1;
        bus.PSW    = '1;
        bus.RPT_EN = '0;
        pin_v      = '1;
        en_v       = '1;

        repeat (3) cyc(1'b1, pin_v, en_v);
        idle(10);

        // clean press, long hold with repeats, release
        pin_v[0] = 1'b0; idle(60);
        pin_v[0] = 1'b1; idle(20);

        // bounce every 3 cycles: never accepted
        for (int i = 0; i < 10; i++) begin
            pin_v[0] = ~pin_v[0];
            idle(3);
        end
        idle(20);

        // long hold with repeat disabled
        en_v = '0;
        pin_v[0] = 1'b0; idle(60);
        pin_v[0] = 1'b1; idle(20);
        en_v = '1;

        // repeat enable dropped and restored while held
        pin_v[0] = 1'b0; idle(32);
        en_v[0] = 1'b0; idle(7);
        en_v[0] = 1'b1; idle(20);
        pin_v[0] = 1'b1; idle(20);

        // release accepted on the long-press edge, then on the first repeat
        pin_v[0] = 1'b0; idle(LONG);
        pin_v[0] = 1'b1; idle(20);
        pin_v[0] = 1'b0; idle(LONG + RPT);
        pin_v[0] = 1'b1; idle(20);

        // both channels together, release ch1 only, then ch0
        pin_v = '0; idle(30);
        pin_v[1] = 1'b1; idle(30);
        pin_v[0] = 1'b1; idle(20);

        // reset while held with pin kept pressed
        pin_v[0] = 1'b0; idle(40);
        repeat (3) cyc(1'b1, pin_v, en_v);
        idle(30);
        pin_v[0] = 1'b1; idle(20);

        // random pin runs, enable flips and rare resets
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 40);
        repeat (3000) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    pin_v[c] = ~pin_v[c];
                    if ($urandom_range(0, 3) == 0) rem[c] = $urandom_range(1, 5);
                    else rem[c] = $urandom_range(6, 60);
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                j = $urandom_range(0, N - 1);
                en_v[j] = ~en_v[j];
            end
            if ($urandom_range(0, 599) == 0) cyc(1'b1, pin_v, en_v);
            else cyc(1'b0, pin_v, en_v);
        end
        idle(5);

        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (popped != pushed || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain popped=%0d want %0d", popped, pushed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of independent push-switch channels (1..16).
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, consecutive stable cycles to accept a level change (>=2).
REQ-003 SHALL have parameter LONG_CYCLES, default 25000000, hold cycles after accepted press before long-press event (>DEB_CYCLES).
REQ-004 SHALL have parameter RPT_CYCLES, default 5000000, auto-repeat period while long-held (>=2).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1, 1 = pin low means pressed.
REQ-006 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port RST  input  1  synchronous active-high reset.
REQ-008 SHALL have port PSW  input  N_KEYS  raw asynchronous switch pins.
REQ-009 SHALL have port RPT_EN  input  N_KEYS  per-channel auto-repeat enable.
REQ-010 SHALL have port KEY_LVL  output  N_KEYS  debounced pressed level, registered.
REQ-011 SHALL have port KEY_PRESS  output  N_KEYS  one-cycle pulse on accepted press.
REQ-012 SHALL have port KEY_REL  output  N_KEYS  one-cycle pulse on accepted release.
REQ-013 SHALL have port KEY_LONG  output  N_KEYS  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-014 SHALL have port KEY_RPT  output  N_KEYS  one-cycle pulse on press and each repeat period.

Function
REQ-015 Each PSW bit SHALL pass a 2-flop synchroniser, then be inverted if ACTIVE_LOW=1, giving s[i] (1 = pressed).
REQ-016 Per channel, a debounce counter (width ceil(log2(DEB_CYCLES+1))) SHALL increment each cycle s[i] != KEY_LVL[i] and clear to 0 any cycle s[i] == KEY_LVL[i].
REQ-017 When the debounce counter equals DEB_CYCLES-1 and s[i] still differs, KEY_LVL[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-018 Latency pin change -> KEY_LVL change SHALL be exactly DEB_CYCLES+2 cycles for a clean step; any bounce restarts the count.
REQ-019 KEY_PRESS[i] / KEY_REL[i] SHALL be high in exactly the cycle KEY_LVL[i] first reads 1 / 0 respectively.
REQ-020 Per-channel FSM states: IDLE, PRESSED, HELD; reset state IDLE.
REQ-021 IDLE -> PRESSED on accepted press; hold counter cleared to 0; KEY_RPT[i] pulses with KEY_PRESS[i] when RPT_EN[i]=1.
REQ-022 In PRESSED the hold counter SHALL increment each cycle; when it reaches LONG_CYCLES-1, KEY_LONG[i] pulses next cycle, FSM -> HELD, repeat counter cleared.
REQ-023 In HELD with RPT_EN[i]=1 the repeat counter SHALL increment and wrap at RPT_CYCLES-1; KEY_RPT[i] pulses on each wrap (first repeat RPT_CYCLES cycles after KEY_LONG).
REQ-024 In HELD with RPT_EN[i]=0 the repeat counter SHALL hold 0 and KEY_RPT[i] SHALL stay 0; re-asserting RPT_EN restarts period from 0.
REQ-025 Accepted release in PRESSED or HELD SHALL go to IDLE, pulse KEY_REL, clear hold/repeat counters; no KEY_LONG or KEY_RPT in the release cycle or after.
REQ-026 Release accepted in the same cycle a LONG or RPT pulse would fire SHALL suppress that pulse (release wins).
REQ-027 Hold and repeat counters SHALL not overflow: HELD never re-fires KEY_LONG.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-029 While RST=1 at a rising edge: synchronisers load "not pressed", all counters 0, FSMs IDLE, all outputs 0.
REQ-030 Reset mid-hold SHALL emit no KEY_REL; after RST falls a still-pressed key SHALL be re-accepted after DEB_CYCLES+2 cycles with KEY_PRESS.

Verification (N_KEYS=2, DEB=4, LONG=20, RPT=5, ACTIVE_LOW=1)
REQ-031 PSW[0] 1->0 clean step at cycle 0 -> KEY_LVL[0]=1 and KEY_PRESS[0] pulse at cycle 6; KEY_RPT[0] pulse same cycle with RPT_EN=1.
REQ-032 PSW[0] toggling every 3 cycles for 30 cycles then steady high -> no KEY_PRESS, no KEY_REL, KEY_LVL[0]=0 throughout.
REQ-033 Hold PSW[0] low 60 cycles, RPT_EN=1 -> KEY_LONG at press+20, KEY_RPT at press, press+25, +30, +35...; release -> one KEY_REL, no further pulses.
REQ-034 Hold with RPT_EN=0 -> single KEY_LONG, zero KEY_RPT after press cycle.
REQ-035 Both channels pressed same cycle -> KEY_PRESS=2'b11 same cycle; release ch1 only -> KEY_REL=2'b10, ch0 continues unchanged.
REQ-036 RST pulsed while ch0 HELD, pin kept low -> outputs 0 during reset, no KEY_REL, KEY_PRESS again 6 cycles after RST deasserts.
